hb_decim_sched: RTL and testbench
=================================

HB_DECIM_SCHED -- requirements
Module: hb_decim_sched

Interface
REQ-001 The module SHALL have parameter DATA_W, default 18, meaning signed sample width (Q1.17) for input and output.
REQ-002 The module SHALL have parameter COEF_W, default 25, meaning signed coefficient width (Q9.16).
REQ-003 The module SHALL have parameter ACC_W, default 48, meaning signed accumulator width.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 Port in_valid, input, 1 bit: in_data carries a sample.
REQ-007 Port in_data, input, DATA_W bits, signed: input sample.
REQ-008 Port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-009 Port out_valid, output, 1 bit: out_data and out_sat are valid.
REQ-010 Port out_data, output, DATA_W bits, signed: decimated filter output.
REQ-011 Port out_ready, input, 1 bit: the consumer takes the output this cycle.
REQ-012 Port out_sat, output, 1 bit: out_data was saturated.
REQ-013 Port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-014 The block SHALL implement an 11-tap halfband decimate-by-2 filter on one shared multiply-accumulate unit: y = sum h[k]*x[n-k], with n the newest sample.
REQ-015 The taps SHALL be fixed: h0=h10=0x209; h2=h8=-0xDE8; h4=h6=0x4BE4; h5=0x8000; h1, h3, h7 and h9 are zero and SHALL NOT be evaluated.
REQ-016 Samples SHALL be kept in a 16-entry circular buffer with a 4-bit write pointer that wraps from 15 to 0; tap k SHALL read entry (wptr_of_newest - k) mod 16.
REQ-017 A sample SHALL be accepted on an edge where in_valid and in_ready are both high; in_ready SHALL equal (state==IDLE).
REQ-018 A phase bit SHALL toggle on each accepted sample. Accepting with phase=0 SHALL store the sample and remain IDLE; accepting with phase=1 SHALL store the sample, clear the accumulator, and enter MAC.
REQ-019 MAC state: one tap per cycle, in order k=0,2,4,5,6,8,10, via a 3-bit tap counter; acc += h[k]*x[n-k], full-precision signed arithmetic at ACC_W.
REQ-020 After the 7th MAC the FSM SHALL enter SAT.
REQ-021 SAT state: acc >>> 16 (arithmetic shift) SHALL be clamped to [-131072, 131071] and registered into out_data.
REQ-022 In SAT, out_sat SHALL be set to 1 iff clamping occurred; out_valid SHALL be set to 1 and the FSM SHALL enter OUT.
REQ-023 Latency: out_valid SHALL first be high after the 8th rising edge following the accepting edge of the phase-1 sample.
REQ-024 OUT state: out_valid, out_data and out_sat SHALL hold stable until an edge with out_ready=1; that edge clears out_valid and returns to IDLE.
REQ-025 out_ready SHALL be ignored when out_valid is 0.
REQ-026 in_valid SHALL be ignored outside IDLE; samples SHALL NOT be dropped internally because the upstream holds them under in_ready=0.
REQ-027 Buffer entries never written since reset SHALL read as zero.

Reset
REQ-028 Asserting rst SHALL immediately force state IDLE, out_valid=0, out_data=0, out_sat=0, busy=0, phase=0, write pointer=0, tap counter=0, accumulator=0, and all 16 buffer entries=0, including when asserted mid-MAC or in OUT.
REQ-029 After rst deasserts, in_ready SHALL be 1 and the first accepted sample SHALL be phase 0.

Verification
REQ-030 Impulse on the phase-0 sample (65536, then zeros; out_ready=1) -> outputs 0, 0, 32768, 0, 0, 0.
REQ-031 Impulse on the phase-1 sample (0, 65536, then zeros) -> outputs 521, -3560, 19428, 19428, -3560, 521, then 0.
REQ-032 Constant 131071 for 24 samples -> from the 6th output onward, out_data=131071 with out_sat=1; constant -131072 -> from the 6th output onward, -131072 with out_sat=1.
REQ-033 Backpressure: out_ready held low for 20 cycles -> out_valid, out_data and in_ready=0 hold steady; the output is released on the first out_ready=1 edge; the next input is accepted exactly one cycle later.
REQ-034 rst pulse during the 4th MAC cycle -> all outputs zero immediately; a subsequent phase-1 impulse test matches REQ-031 exactly, with no residue from prior data.
REQ-035 Wrap-around: 40 random samples with random in_valid and out_ready gaps -> every output matches a bit-exact reference model including saturation, with the pointer wrapping at least twice.

Source files
------------

// File: rtl/hb_decim_sched.sv
// hb_decim_sched: 11-tap halfband decimate-by-2 filter built around a single
// shared multiply-accumulate unit.
//
// Every sample is written into a 16-entry circular buffer. Each second
// accepted sample (phase 1) starts a computation: 7 MAC cycles over the
// non-zero taps, one saturation cycle, and then the result is held until the
// consumer takes it.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous active-high reset
//   in_valid   : in_data carries a sample
//   in_data    : signed input sample (Q1.17 at default width)
//   in_ready   : block accepts a sample this cycle (state IDLE)
//   out_valid  : out_data / out_sat are valid
//   out_data   : signed decimated output sample
//   out_ready  : consumer takes the output this cycle
//   out_sat    : out_data was clamped
//   busy       : state is not IDLE
//
// State | meaning
// IDLE  | waiting for input samples; in_ready high
// MAC   | one tap per cycle, k = 0,2,4,5,6,8,10
// SAT   | shift, clamp and register the result
// OUT   | hold the result until out_ready
module hb_decim_sched #(
  parameter int DATA_W = 18,
  parameter int COEF_W = 25,
  parameter int ACC_W  = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  input  logic                     out_ready,
  output logic                     out_sat,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, MAC, SAT, OUT} state_t;

  // Coefficients are Q9.16, so the product carries 16 extra fraction bits.
  localparam int C_FRAC = 16;
  localparam logic signed [COEF_W-1:0] C_H0 = COEF_W'(521);
  localparam logic signed [COEF_W-1:0] C_H2 = COEF_W'(-3560);
  localparam logic signed [COEF_W-1:0] C_H4 = COEF_W'(19428);
  localparam logic signed [COEF_W-1:0] C_H5 = COEF_W'(32768);
  localparam longint C_MAX_L = (longint'(1) << (DATA_W - 1)) - 1;
  localparam logic signed [ACC_W-1:0] C_MAX = ACC_W'(C_MAX_L);
  localparam logic signed [ACC_W-1:0] C_MIN = ACC_W'(-C_MAX_L - 1);

  state_t                    r_state;
  logic                      r_phase;
  logic [3:0]                r_wptr;
  logic [2:0]                r_tap;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [DATA_W-1:0]  r_buf [16];
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_out_data;
  logic                      r_out_sat;

  logic [3:0]                w_k;
  logic signed [COEF_W-1:0]  w_coef;
  logic [3:0]                w_idx;
  logic signed [DATA_W-1:0]  w_x;
  logic signed [ACC_W-1:0]   w_x_ext;
  logic signed [ACC_W-1:0]   w_coef_ext;
  logic signed [ACC_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]   w_shift;
  logic                      w_hi;
  logic                      w_lo;
  logic signed [DATA_W-1:0]  w_sat_data;

  // Tap counter -> (delay k, coefficient); odd taps other than 5 are zero
  // and are skipped entirely.
  always_comb begin
    w_k    = 4'd0;
    w_coef = '0;
    unique case (r_tap)
      3'd0: begin w_k = 4'd0;  w_coef = C_H0; end
      3'd1: begin w_k = 4'd2;  w_coef = C_H2; end
      3'd2: begin w_k = 4'd4;  w_coef = C_H4; end
      3'd3: begin w_k = 4'd5;  w_coef = C_H5; end
      3'd4: begin w_k = 4'd6;  w_coef = C_H4; end
      3'd5: begin w_k = 4'd8;  w_coef = C_H2; end
      3'd6: begin w_k = 4'd10; w_coef = C_H0; end
      default: begin w_k = 4'd0; w_coef = '0; end
    endcase
  end

  // r_wptr points at the next free slot, so the newest sample is r_wptr-1.
  assign w_idx      = r_wptr - 4'd1 - w_k;
  assign w_x        = r_buf[w_idx];
  assign w_x_ext    = ACC_W'(w_x);
  assign w_coef_ext = ACC_W'(w_coef);
  assign w_prod     = w_x_ext * w_coef_ext;

  assign w_shift    = r_acc >>> C_FRAC;
  assign w_hi       = (w_shift > C_MAX);
  assign w_lo       = (w_shift < C_MIN);
  assign w_sat_data = w_hi ? C_MAX[DATA_W-1:0] :
                      w_lo ? C_MIN[DATA_W-1:0] : w_shift[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_phase     <= 1'b0;
      r_wptr      <= 4'd0;
      r_tap       <= 3'd0;
      r_acc       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_buf[r_wptr] <= in_data;
            r_wptr        <= r_wptr + 4'd1;
            r_phase       <= ~r_phase;
            if (r_phase) begin
              r_acc   <= '0;
              r_tap   <= 3'd0;
              r_state <= MAC;
            end
          end
        end
        MAC: begin
          r_acc <= r_acc + w_prod;
          if (r_tap == 3'd6) begin
            r_tap   <= 3'd0;
            r_state <= SAT;
          end else begin
            r_tap <= r_tap + 3'd1;
          end
        end
        SAT: begin
          r_out_data  <= w_sat_data;
          r_out_sat   <= w_hi | w_lo;
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_hb_decim_sched.sv
// Directed testbench for hb_decim_sched: impulse responses, saturation,
// backpressure, mid-computation reset and a randomised wrap-around run
// checked against a direct-form convolution of the accepted sample history.
module tb_hb_decim_sched;
  localparam int DW = 18;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready, out_sat, busy;
  logic signed [DW-1:0] in_data, out_data;

  int checks = 0;
  int errors = 0;
  int hist[$];

  always #5 clk = ~clk;

  hb_decim_sched dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .out_sat(out_sat), .busy(busy)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct convolution over everything accepted since the last reset.
  function automatic logic signed [63:0] model_y(output logic sat);
    int     kk[7] = '{0, 2, 4, 5, 6, 8, 10};
    longint hh[7] = '{521, -3560, 19428, 32768, 19428, -3560, 521};
    longint acc = 0;
    longint y;
    int idx;
    for (int i = 0; i < 7; i++) begin
      idx = hist.size() - 1 - kk[i];
      if (idx >= 0) acc += hh[i] * longint'(hist[idx]);
    end
    y = acc >>> 16;
    sat = 1'b0;
    if (y > 131071) begin y = 131071; sat = 1'b1; end
    else if (y < -131072) begin y = -131072; sat = 1'b1; end
    return y;
  endfunction

  // Called and returns at a falling edge; the sample is accepted on the
  // rising edge in between.
  task automatic push(input int x);
    int t = 0;
    in_data  = x[17:0];
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    chk("push_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    hist.push_back(x);
  endtask

  task automatic expect_out(input string tag, input logic signed [63:0] exp_d,
                            input logic exp_s);
    int t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, $signed(out_data), exp_d);
    chk({tag, "_sat"}, out_sat, exp_s);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_release"}, out_valid, 0);
  endtask

  task automatic expect_model(input string tag);
    logic s;
    logic signed [63:0] y;
    y = model_y(s);
    expect_out(tag, y, s);
  endtask

  initial begin
    int e0[6] = '{0, 0, 32768, 0, 0, 0};
    int e1[7] = '{521, -3560, 19428, 19428, -3560, 521, 0};
    int t;
    logic signed [DW-1:0] held;
    logic signed [63:0] y;
    logic s;
    logic [17:0] rv;
    int x, r;
    bit released;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", $signed(out_data), 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);

    // Impulse on the phase-0 sample, with a latency check on the first output.
    push(65536);
    push(0);
    chk("mac_busy", busy, 1);
    chk("mac_in_ready", in_ready, 0);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    chk("latency", t, 8);
    expect_out("imp0", e0[0], 1'b0);
    for (int i = 1; i < 6; i++) begin
      push(0); push(0);
      expect_out("imp0", e0[i], 1'b0);
    end

    // Impulse on the phase-1 sample.
    push(0); push(65536);
    expect_out("imp1", e1[0], 1'b0);
    for (int i = 1; i < 7; i++) begin
      push(0); push(0);
      expect_out("imp1", e1[i], 1'b0);
    end

    // Full-scale constants saturate once the window fills.
    for (int i = 0; i < 12; i++) begin
      push(131071); push(131071);
      if (i >= 5) expect_out("sat_pos", 131071, 1'b1);
      else expect_model("ramp_pos");
    end
    for (int i = 0; i < 12; i++) begin
      push(-131072); push(-131072);
      if (i >= 5) expect_out("sat_neg", -131072, 1'b1);
      else expect_model("ramp_neg");
    end

    // Backpressure: the output and in_ready hold while out_ready is low.
    push(1000); push(-2000);
    t = 0;
    while (!out_valid && t < 50) begin @(negedge clk); t++; end
    y = model_y(s);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", $signed(out_data), y);
    chk("bp_sat", out_sat, s);
    held = out_data;
    in_valid = 1'b1; in_data = 18'sd3000;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_data", $signed(out_data), held);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    hist.push_back(3000);
    @(negedge clk);
    chk("bp_next_idle", busy, 0);
    in_data = 18'sd4000;
    @(negedge clk);
    in_valid = 1'b0;
    hist.push_back(4000);
    chk("bp_next_busy", busy, 1);
    expect_model("bp_next");

    // Reset during the fourth MAC cycle, then a clean phase-1 impulse.
    push(77777); push(-55555);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", $signed(out_data), 0);
    chk("midrst_out_sat", out_sat, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    hist.delete();
    push(0); push(65536);
    expect_out("post_rst", e1[0], 1'b0);
    for (int i = 1; i < 7; i++) begin
      push(0); push(0);
      expect_out("post_rst", e1[i], 1'b0);
    end

    // Random samples with gaps on both handshakes; pointer wraps repeatedly.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 3);
      if (r != 0) x = (((i / 10) % 2) == 0) ? 131071 : -131072;
      else begin
        rv = 18'($urandom);
        x = $signed(rv);
      end
      push(x);
      if ((i % 2) == 1) begin
        t = 0;
        while (!out_valid && t < 50) begin @(negedge clk); t++; end
        y = model_y(s);
        chk("rnd_valid", out_valid, 1);
        chk("rnd_data", $signed(out_data), y);
        chk("rnd_sat", out_sat, s);
        held = out_data;
        released = 1'b0;
        t = 0;
        while (!released && t < 50) begin
          r = $urandom_range(0, 1);
          out_ready = 1'(r);
          @(negedge clk);
          if (r == 1) released = 1'b1;
          else begin
            chk("rnd_hold_valid", out_valid, 1);
            chk("rnd_hold_data", $signed(out_data), held);
          end
          t++;
        end
        out_ready = 1'b0;
        chk("rnd_release", out_valid, 0);
      end
    end
    out_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
